// File: rtl/riscv_div_radix.sv
// Iterative RV M-extension divider (DIV/DIVU/REM/REMU and W forms), BITS_PER_CYCLE quotient bits per clock.
// Optional early termination on dividend leading zeros: define RISCV_DIV_EARLY_TERM_EN.
module riscv_div_radix #(
  parameter int XLEN           = 64,
  parameter int ILEN           = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            div_stall,
  input  logic            id_bubble,
  input  logic [ILEN-1:0] id_instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  output logic            div_bubble,
  output logic [XLEN-1:0] div_r
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {CHK, DIV, RES} state_t;
  state_t state, state_nxt;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

`ifdef RISCV_DIV_EARLY_TERM_EN
  function automatic int clz(input logic [XLEN-1:0] v);
    int z;
    z = XLEN;
    for (int i = 0; i < XLEN; i++)
      if (v[i]) z = XLEN - 1 - i;
    return z;
  endfunction
`endif

  // Decode
  logic [6:0] func7;
  logic [2:0] func3;
  logic [4:0] opc;
  logic       op_w, op_valid, op_signed, op_rem, accept;
  logic       unused_instr;

  assign func7     = id_instr[31:25];
  assign func3     = id_instr[14:12];
  assign opc       = id_instr[6:2];
  assign op_w      = (opc == 5'b01110);
  assign op_valid  = (func7 == 7'b0000001) && func3[2] &&
                     ((opc == 5'b01100) || (op_w && (XLEN == 64) && (st_xlen != 2'b01)));
  assign op_signed = ~func3[0];
  assign op_rem    = func3[1];
  assign accept    = (state == CHK) && op_valid && !ex_stall && !id_bubble && !ex_flush;
  assign unused_instr = ^id_instr;

  // Operand preparation and single-cycle special cases
  logic [31:0]     a32, b32, abs_a32, abs_b32;
  logic            sign_a, sign_b, div_zero, ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, a_init, a_load, fast_res;
  logic [CW-1:0]   cnt_load;
  int              w_bits, n_iter;
`ifdef RISCV_DIV_EARLY_TERM_EN
  int              lz, pre;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    a32      = opA[31:0];
    b32      = opB[31:0];
    sign_a   = op_signed & (op_w ? a32[31] : opA[XLEN-1]);
    sign_b   = op_signed & (op_w ? b32[31] : opB[XLEN-1]);
    abs_a32  = sign_a ? (~a32 + 32'd1) : a32;
    abs_b32  = sign_b ? (~b32 + 32'd1) : b32;
    mag_a    = op_w ? XLEN'(abs_a32) : (sign_a ? (~opA + XLEN'(1)) : opA);
    mag_b    = op_w ? XLEN'(abs_b32) : (sign_b ? (~opB + XLEN'(1)) : opB);
    div_zero = op_w ? (b32 == '0) : (opB == '0);
    ovf      = op_signed && (op_w ? (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                                  : (opA == MIN_VAL && (&opB)));
    fast     = div_zero | ovf;
    if (div_zero)
      fast_res = op_rem ? (op_w ? sext32(a32) : opA) : '1;
    else
      fast_res = op_rem ? '0 : (op_w ? sext32(32'h8000_0000) : MIN_VAL);

    // W-form dividends live in the top half so the quotient lands in bits [31:0].
    a_init = op_w ? (mag_a << (XLEN - 32)) : mag_a;
    w_bits = op_w ? 32 : XLEN;
`ifdef RISCV_DIV_EARLY_TERM_EN
    lz = clz(a_init);
    if (lz > w_bits) lz = w_bits;
    pre    = (lz / BITS_PER_CYCLE) * BITS_PER_CYCLE;
    a_load = a_init << pre;
    n_iter = (lz == w_bits) ? 1 : (w_bits - pre) / BITS_PER_CYCLE;
`else
    a_load = a_init;
    n_iter = w_bits / BITS_PER_CYCLE;
`endif
    cnt_load = CW'(n_iter - 1);
  end

  // Iteration datapath: p = partial remainder, a = dividend/quotient shift register
  logic [XLEN-1:0] p, a, b, p_nxt, a_nxt, q_val, r_val, sel, res;
  logic [XLEN:0]   trial, diff;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, w_q, rem_q;

  // NOTE: blocking assignments chain the restoring steps within one clock; state is updated with <= below.
  always_comb begin
    p_nxt = p;
    a_nxt = a;
    trial = '0;
    diff  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      trial = {p_nxt, a_nxt[XLEN-1]};
      diff  = trial - {1'b0, b};
      if (!diff[XLEN]) begin
        p_nxt = diff[XLEN-1:0];
        a_nxt = {a_nxt[XLEN-2:0], 1'b1};
      end else begin
        p_nxt = trial[XLEN-1:0];
        a_nxt = {a_nxt[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_val = neg_q ? (~a + XLEN'(1)) : a;
    r_val = neg_r ? (~p + XLEN'(1)) : p;
    sel   = rem_q ? r_val : q_val;
    res   = w_q ? sext32(sel[31:0]) : sel;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CHK:     if (accept && !fast) state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = RES;
      RES:     state_nxt = CHK;
      default: state_nxt = CHK;
    endcase
    if (ex_flush) state_nxt = CHK;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= CHK;
    else       state <= state_nxt;
  end

  assign div_stall = (state == DIV);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p          <= '0;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      w_q        <= 1'b0;
      rem_q      <= 1'b0;
      div_bubble <= 1'b1;
      div_r      <= '0;
    end else begin
      div_bubble <= 1'b1;
      if (!ex_flush) begin
        unique case (state)
          CHK: if (accept) begin
            w_q   <= op_w;
            rem_q <= op_rem;
            if (fast) begin
              div_r      <= fast_res;
              div_bubble <= 1'b0;
            end else begin
              p     <= '0;
              a     <= a_load;
              b     <= mag_b;
              cnt   <= cnt_load;
              neg_q <= sign_a ^ sign_b;
              neg_r <= sign_a;
            end
          end
          DIV: begin
            p   <= p_nxt;
            a   <= a_nxt;
            cnt <= cnt - CW'(1);
          end
          RES: begin
            div_r      <= res;
            div_bubble <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
